// File: rtl/rp8_bd_pkg.sv
// Shared types and helpers for the rp8 data-bus arbiters.
// Records are sized for the widest rp8 geometry; narrower instances zero-extend into them.
package rp8_bd_pkg;

  localparam int BD_DAW = 13;
  localparam int BD_IDW = 6;
  localparam int BD_DW  = 8;

  typedef struct packed {
    logic              wen;
    logic              lck;
    logic [BD_DAW-1:0] adr;
    logic [BD_IDW-1:0] wid;
    logic [BD_DW-1:0]  wdt;
  } bd_req_t;

  typedef struct packed {
    logic              ren;
    logic [BD_IDW-1:0] rid;
    logic [BD_DW-1:0]  rdt;
  } bd_rsp_t;

  // Highest set bit wins; callers only pass one-hot or zero vectors.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    onehot2idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) onehot2idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rp8_bd_arb_if.sv
// Bundle of the requester-side bd_* buses and the single-port RAM port.
interface rp8_bd_arb_if #(
  parameter int NRQ = 2,
  parameter int DAW = 13,
  parameter int IDW = 6
);

  logic [NRQ-1:0]     rq_req;
  logic [NRQ-1:0]     rq_wen;
  logic [NRQ-1:0]     rq_lck;
  logic [NRQ*DAW-1:0] rq_adr;
  logic [NRQ*IDW-1:0] rq_wid;
  logic [NRQ*8-1:0]   rq_wdt;
  logic [NRQ-1:0]     rq_ack;
  logic [NRQ-1:0]     rq_ren;
  logic [IDW-1:0]     rq_rid;
  logic [7:0]         rq_rdt;
  logic               m_req;
  logic               m_wen;
  logic [DAW-1:0]     m_adr;
  logic [7:0]         m_wdt;
  logic [7:0]         m_rdt;

  // Arbiter side.
  modport slave (
    input  rq_req, rq_wen, rq_lck, rq_adr, rq_wid, rq_wdt, m_rdt,
    output rq_ack, rq_ren, rq_rid, rq_rdt, m_req, m_wen, m_adr, m_wdt
  );

  // Requesters plus RAM side.
  modport master (
    output rq_req, rq_wen, rq_lck, rq_adr, rq_wid, rq_wdt, m_rdt,
    input  rq_ack, rq_ren, rq_rid, rq_rdt, m_req, m_wen, m_adr, m_wdt
  );

endinterface

// File: rtl/rp8_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Shared by the data-bus and io-bus arbiters.
module rp8_rr_arb
  import rp8_bd_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] c;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = IW'((32'(ptr_i) + k) % 32'(N));
      if (!found && req_i[c]) begin
        gnt_o[c] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign idx_o = IW'(onehot2idx(8'(gnt_o)));

endmodule

// File: rtl/rp8_bd_arb.sv
// Round-robin arbiter sharing one synchronous single-port data RAM between
// NRQ bd masters, with access lock and a one-stage read-return path.
module rp8_bd_arb
  import rp8_bd_pkg::*;
#(
  parameter int NRQ = 2,
  parameter int DAW = 13,
  parameter int IDW = 6
) (
  input  logic         clk,
  input  logic         rst,
  rp8_bd_arb_if.slave  bd
);

  localparam int IW = (NRQ > 1) ? $clog2(NRQ) : 1;

  logic [IW-1:0]  ptr_q, ptr_d;
  logic           lck_vld_q, lck_vld_d;
  logic [IW-1:0]  own_q, own_d;
  logic           rd_vld_q, rd_vld_d;
  logic [IW-1:0]  rd_own_q, rd_own_d;
  logic [IDW-1:0] rd_id_q, rd_id_d;

  bd_req_t        req_a [NRQ];
  bd_req_t        sel;
  bd_rsp_t        rsp;
  logic [NRQ-1:0] rr_gnt;
  logic [IW-1:0]  rr_idx;
  logic [NRQ-1:0] own_oh;
  logic [NRQ-1:0] rd_oh;
  logic [NRQ-1:0] gnt_oh;
  logic [IW-1:0]  gnt_idx;
  logic           any_req;
  logic           lock_hold;

  always_comb begin
    for (int unsigned i = 0; i < NRQ; i++) begin
      req_a[i].wen = bd.rq_wen[i];
      req_a[i].lck = bd.rq_lck[i];
      req_a[i].adr = BD_DAW'(bd.rq_adr[i*DAW +: DAW]);
      req_a[i].wid = BD_IDW'(bd.rq_wid[i*IDW +: IDW]);
      req_a[i].wdt = bd.rq_wdt[i*8 +: 8];
    end
  end

  rp8_rr_arb #(.N(NRQ)) u_rr (
    .req_i (bd.rq_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  always_comb begin
    own_oh        = '0;
    own_oh[own_q] = 1'b1;
    rd_oh           = '0;
    rd_oh[rd_own_q] = 1'b1;
  end

  // A waiting owner keeps the bus; an idle owner lets normal arbitration run.
  assign any_req   = |bd.rq_req;
  assign lock_hold = lck_vld_q & bd.rq_req[own_q];
  assign gnt_oh    = lock_hold ? own_oh : rr_gnt;
  assign gnt_idx   = lock_hold ? own_q  : rr_idx;
  assign sel       = req_a[gnt_idx];

  assign bd.m_req  = any_req;
  assign bd.m_wen  = any_req & sel.wen;
  assign bd.m_adr  = DAW'(sel.adr);
  assign bd.m_wdt  = sel.wdt;
  assign bd.rq_ack = gnt_oh;

  always_comb begin
    ptr_d = ptr_q;
    if (any_req && !lock_hold) begin
      ptr_d = (gnt_idx == IW'(NRQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    lck_vld_d = lck_vld_q;
    own_d     = own_q;
    if (lock_hold) begin
      if (!sel.lck) lck_vld_d = 1'b0;
    end else begin
      lck_vld_d = any_req & sel.lck;
      if (any_req && sel.lck) own_d = gnt_idx;
    end
  end

  always_comb begin
    rd_vld_d = any_req & ~sel.wen;
    rd_own_d = rd_own_q;
    rd_id_d  = rd_id_q;
    if (rd_vld_d) begin
      rd_own_d = gnt_idx;
      rd_id_d  = IDW'(sel.wid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      lck_vld_q <= 1'b0;
      own_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_own_q  <= '0;
      rd_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lck_vld_q <= lck_vld_d;
      own_q     <= own_d;
      rd_vld_q  <= rd_vld_d;
      rd_own_q  <= rd_own_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // RAM data is passed straight through; the registered stage only tags it.
  always_comb begin
    rsp.ren = rd_vld_q;
    rsp.rid = BD_IDW'(rd_id_q);
    rsp.rdt = bd.m_rdt;
  end

  assign bd.rq_ren = rsp.ren ? rd_oh : '0;
  assign bd.rq_rid = IDW'(rsp.rid);
  assign bd.rq_rdt = rsp.rdt;

endmodule

// File: tb/tb_rp8_bd_arb.sv
// Directed bench for rp8_bd_arb: a 2-master instance and a 3-master instance,
// each attached to a behavioural 1-cycle-latency RAM.
module tb_rp8_bd_arb;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rp8_bd_arb_if #(.NRQ(2), .DAW(13), .IDW(6)) b2 ();
  rp8_bd_arb_if #(.NRQ(3), .DAW(13), .IDW(6)) b3 ();

  rp8_bd_arb #(.NRQ(2), .DAW(13), .IDW(6)) d2 (.clk(clk), .rst(rst), .bd(b2.slave));
  rp8_bd_arb #(.NRQ(3), .DAW(13), .IDW(6)) d3 (.clk(clk), .rst(rst), .bd(b3.slave));

  logic [7:0] mem2 [8192];
  logic [7:0] mem3 [8192];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b2.m_req) begin
      if (b2.m_wen) mem2[b2.m_adr] <= b2.m_wdt;
      else          b2.m_rdt <= mem2[b2.m_adr];
    end
  end

  always @(posedge clk) begin
    if (b3.m_req) begin
      if (b3.m_wen) mem3[b3.m_adr] <= b3.m_wdt;
      else          b3.m_rdt <= mem3[b3.m_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int m, input logic req, input logic wen, input logic lck,
                      input logic [12:0] adr, input logic [5:0] wid, input logic [7:0] wdt);
    b2.rq_req[m]          = req;
    b2.rq_wen[m]          = wen;
    b2.rq_lck[m]          = lck;
    b2.rq_adr[m*13 +: 13] = adr;
    b2.rq_wid[m*6 +: 6]   = wid;
    b2.rq_wdt[m*8 +: 8]   = wdt;
  endtask

  task automatic set3(input int m, input logic req, input logic wen, input logic lck,
                      input logic [12:0] adr, input logic [5:0] wid, input logic [7:0] wdt);
    b3.rq_req[m]          = req;
    b3.rq_wen[m]          = wen;
    b3.rq_lck[m]          = lck;
    b3.rq_adr[m*13 +: 13] = adr;
    b3.rq_wid[m*6 +: 6]   = wid;
    b3.rq_wdt[m*8 +: 8]   = wdt;
  endtask

  initial begin
    int g3 [4];
    g3[0] = 2; g3[1] = 0; g3[2] = 1; g3[3] = 2;
    n_chk = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    b2.rq_req = '0; b2.rq_wen = '0; b2.rq_lck = '0;
    b2.rq_adr = '0; b2.rq_wid = '0; b2.rq_wdt = '0;
    b3.rq_req = '0; b3.rq_wen = '0; b3.rq_lck = '0;
    b3.rq_adr = '0; b3.rq_wid = '0; b3.rq_wdt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_mreq", 32'(b2.m_req), 32'h0);
      chk("idle_ack",  32'(b2.rq_ack), 32'h0);
      chk("idle_ren",  32'(b2.rq_ren), 32'h0);
      tick();
    end
    chk("idle_rid", 32'(b2.rq_rid), 32'h0);

    // Core write then read-back of the same address
    set2(0, 1, 1, 0, 13'h0123, 6'd0, 8'hA5);
    #1;
    chk("wr_ack",  32'(b2.rq_ack), 32'h1);
    chk("wr_mreq", 32'(b2.m_req),  32'h1);
    chk("wr_mwen", 32'(b2.m_wen),  32'h1);
    chk("wr_madr", 32'(b2.m_adr),  32'h0123);
    chk("wr_mwdt", 32'(b2.m_wdt),  32'hA5);
    tick();
    chk("wr_noren", 32'(b2.rq_ren), 32'h0);
    set2(0, 1, 0, 0, 13'h0123, 6'd5, 8'h00);
    #1;
    chk("rd_ack",  32'(b2.rq_ack), 32'h1);
    chk("rd_mwen", 32'(b2.m_wen),  32'h0);
    tick();
    chk("rd_ren", 32'(b2.rq_ren), 32'h1);
    chk("rd_rid", 32'(b2.rq_rid), 32'd5);
    chk("rd_rdt", 32'(b2.rq_rdt), 32'hA5);

    // No request: m_wen forced low, address shows master 0
    set2(0, 0, 1, 0, 13'h0055, 6'd0, 8'h77);
    #1;
    chk("nreq_mreq", 32'(b2.m_req),  32'h0);
    chk("nreq_mwen", 32'(b2.m_wen),  32'h0);
    chk("nreq_madr", 32'(b2.m_adr),  32'h0055);
    chk("nreq_ack",  32'(b2.rq_ack), 32'h0);
    tick();
    chk("nreq_ren", 32'(b2.rq_ren), 32'h0);

    // Master 1 write (ptr 1 -> 0), then both read continuously
    set2(1, 1, 1, 0, 13'h0200, 6'd0, 8'h3C);
    #1;
    chk("m1wr_ack", 32'(b2.rq_ack), 32'h2);
    tick();
    set2(0, 1, 0, 0, 13'h0123, 6'd1, 8'h00);
    set2(1, 1, 0, 0, 13'h0200, 6'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ack",  32'(b2.rq_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_madr", 32'(b2.m_adr),  (i % 2 == 0) ? 32'h0123 : 32'h0200);
      tick();
      chk("alt_ren", 32'(b2.rq_ren), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_rid", 32'(b2.rq_rid), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_rdt", 32'(b2.rq_rdt), (i % 2 == 0) ? 32'hA5 : 32'h3C);
    end

    // Master 1 locked writes while master 0 keeps requesting (ptr = 0)
    set2(0, 1, 0, 0, 13'h0123, 6'd7, 8'h00);
    set2(1, 1, 1, 1, 13'h0300, 6'd0, 8'h11);
    #1;
    chk("lk_c1_ack", 32'(b2.rq_ack), 32'h1);
    tick();
    chk("lk_c1_ren", 32'(b2.rq_ren), 32'h1);
    chk("lk_c1_rid", 32'(b2.rq_rid), 32'd7);
    #1;
    chk("lk_c2_ack", 32'(b2.rq_ack), 32'h2);
    chk("lk_c2_wdt", 32'(b2.m_wdt),  32'h11);
    tick();
    chk("lk_c2_ren", 32'(b2.rq_ren), 32'h0);
    set2(1, 1, 1, 1, 13'h0301, 6'd0, 8'h22);
    #1;
    chk("lk_c3_ack", 32'(b2.rq_ack), 32'h2);
    tick();
    set2(1, 1, 1, 0, 13'h0302, 6'd0, 8'h33);
    #1;
    chk("lk_c4_ack",  32'(b2.rq_ack), 32'h2);
    chk("lk_c4_madr", 32'(b2.m_adr),  32'h0302);
    tick();
    #1;
    chk("lk_c5_ack", 32'(b2.rq_ack), 32'h1);
    tick();
    chk("lk_c5_ren", 32'(b2.rq_ren), 32'h1);
    chk("lk_c5_rid", 32'(b2.rq_rid), 32'd7);
    set2(0, 0, 0, 0, 13'h0, 6'd0, 8'h00);
    set2(1, 0, 0, 0, 13'h0, 6'd0, 8'h00);

    // Lock set by master 1, released when it goes idle (ptr = 1)
    set2(1, 1, 0, 1, 13'h0301, 6'd3, 8'h00);
    #1;
    chk("rel_c1_ack", 32'(b2.rq_ack), 32'h2);
    tick();
    chk("rel_c1_ren", 32'(b2.rq_ren), 32'h2);
    chk("rel_c1_rid", 32'(b2.rq_rid), 32'd3);
    chk("rel_c1_rdt", 32'(b2.rq_rdt), 32'h22);
    set2(1, 0, 0, 0, 13'h0, 6'd0, 8'h00);
    set2(0, 1, 0, 0, 13'h0123, 6'd4, 8'h00);
    #1;
    chk("rel_c2_ack", 32'(b2.rq_ack), 32'h1);
    tick();
    chk("rel_c2_ren", 32'(b2.rq_ren), 32'h1);
    chk("rel_c2_rdt", 32'(b2.rq_rdt), 32'hA5);
    set2(1, 1, 0, 0, 13'h0302, 6'd6, 8'h00);
    #1;
    chk("rel_c3_ack", 32'(b2.rq_ack), 32'h2);
    tick();
    chk("rel_c3_ren", 32'(b2.rq_ren), 32'h2);
    chk("rel_c3_rid", 32'(b2.rq_rid), 32'd6);
    chk("rel_c3_rdt", 32'(b2.rq_rdt), 32'h33);
    #1;
    chk("rel_c4_ack", 32'(b2.rq_ack), 32'h1);
    tick();
    chk("rel_c4_ren", 32'(b2.rq_ren), 32'h1);
    set2(0, 0, 0, 0, 13'h0, 6'd0, 8'h00);
    set2(1, 0, 0, 0, 13'h0, 6'd0, 8'h00);

    // Reset while a read return is pending
    set2(0, 1, 0, 0, 13'h0123, 6'd9, 8'h00);
    #1;
    chk("rstrd_ack", 32'(b2.rq_ack), 32'h1);
    tick();
    set2(0, 0, 0, 0, 13'h0, 6'd0, 8'h00);
    chk("rstrd_ren_pre", 32'(b2.rq_ren), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstrd_ren_async", 32'(b2.rq_ren), 32'h0);
    chk("rstrd_rid_async", 32'(b2.rq_rid), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstrd_ren_post", 32'(b2.rq_ren), 32'h0);

    // Three masters: steer ptr to 2, then all request
    set3(1, 1, 0, 0, 13'h0011, 6'd11, 8'h00);
    #1;
    chk("n3_pre_ack", 32'(b3.rq_ack), 32'h2);
    tick();
    chk("n3_pre_ren", 32'(b3.rq_ren), 32'h2);
    chk("n3_pre_rid", 32'(b3.rq_rid), 32'd11);
    set3(0, 1, 0, 0, 13'h0010, 6'd10, 8'h00);
    set3(2, 1, 0, 0, 13'h0012, 6'd12, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("n3_ack",  32'(b3.rq_ack), 32'h1 << g3[i]);
      chk("n3_madr", 32'(b3.m_adr),  32'h10 + 32'(g3[i]));
      tick();
      chk("n3_ren", 32'(b3.rq_ren), 32'h1 << g3[i]);
      chk("n3_rid", 32'(b3.rq_rid), 32'd10 + 32'(g3[i]));
    end
    b3.rq_req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
